// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared FSM type, default header-length field position and length helper
package noc_arb_pkg;
   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
   localparam int LEN_LSB_DEF = 22;
   localparam int LEN_W_DEF = 8;
   localparam int FLIT_MAX = 512;
   typedef logic [FLIT_MAX-1:0] flit_t;
   function automatic logic [31:0] hdr_len(input flit_t flit, input int lsb);
      return 32'(flit >> lsb);
   endfunction
endpackage

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: rotating-priority picker, first valid requester at or above ptr with wrap
module noc_rr_pick #(
   parameter int N = 4,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (valid[(int'(ptr) + k) % N]) begin
            idx = PW'((int'(ptr) + k) % N);
            any = 1'b1;
         end
      end
      grant = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/noc_credit_arbiter.sv
// noc_credit_arbiter: packet-atomic round-robin arbiter onto one credit (valid/yummy) NoC link
// Defining NOC_ARB_STATS_EN adds per-requester packet counters and a credit-stall counter.
module noc_credit_arbiter import noc_arb_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int DATA_WIDTH = 64,
   parameter int CREDITS = 8,
   parameter int LEN_LSB = LEN_LSB_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   input  logic                        out_yummy,
`ifdef NOC_ARB_STATS_EN
   output logic [N_REQ*32-1:0]         stat_pkts,
   output logic [31:0]                 stat_stall,
`endif
   output logic                        credit_err
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(CREDITS + 1);
   arb_state_e state;
   logic [IW-1:0] rr_ptr, grant_q, cur_idx, pick_idx, next_ptr;
   logic [N_REQ-1:0] pick_grant;
   logic pick_any, accept, last, send_only, yum_only;
   logic [CW-1:0] cred;
   logic [LEN_W-1:0] remain, len;
   logic [DATA_WIDTH-1:0] cur_flit;
   noc_rr_pick #(.N(N_REQ)) u_pick (
      .valid(req_valid),
      .ptr(rr_ptr),
      .grant(pick_grant),
      .idx(pick_idx),
      .any(pick_any)
   );
   always_comb begin
      cur_idx   = state == IDLE ? pick_idx : grant_q;
      cur_flit  = req_data[cur_idx*DATA_WIDTH +: DATA_WIDTH];
      len       = LEN_W'(hdr_len(flit_t'(cur_flit), LEN_LSB));
      // ready is held low while in reset so nothing is taken from the requesters
      accept    = rst_n && cred != '0 && (state == IDLE ? pick_any : req_valid[grant_q]);
      req_ready = accept ? (state == IDLE ? pick_grant : N_REQ'(1) << grant_q) : '0;
      last      = state == IDLE ? len == '0 : remain == LEN_W'(1);
      next_ptr  = cur_idx == IW'(N_REQ - 1) ? '0 : cur_idx + 1'b1;
      send_only = accept && !out_yummy;
      yum_only  = out_yummy && !accept;
   end
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_q    <= '0;
         remain     <= '0;
         cred       <= CW'(CREDITS);
         credit_err <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         out_valid  <= accept;
         cred       <= send_only ? cred - 1'b1 : yum_only && cred != CW'(CREDITS) ? cred + 1'b1 : cred;
         credit_err <= credit_err | (yum_only && cred == CW'(CREDITS));
         if (accept) begin
            out_data <= cur_flit;
            grant_q  <= cur_idx;
            remain   <= state == IDLE ? len : remain - 1'b1;
            state    <= last ? IDLE : BURST;
            if (last) rr_ptr <= next_ptr;
         end
      end
   end
`ifdef NOC_ARB_STATS_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         stat_pkts  <= '0;
         stat_stall <= '0;
      end else begin
         if (accept && last) stat_pkts[cur_idx*32 +: 32] <= stat_pkts[cur_idx*32 +: 32] + 32'd1;
         if (|req_valid && cred == '0) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_noc_credit_arbiter.sv
// tb_noc_credit_arbiter: scoreboard bench against a packet-level round-robin reference model
module tb_noc_credit_arbiter;
   localparam int N = 4, W = 64, C = 8, LL = 22, LW = 8;
   logic clock = 1'b0, rst_n = 1'b0, out_yummy = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [N*W-1:0] req_data = '0;
   logic out_valid, credit_err;
   logic [W-1:0] out_data;
`ifdef NOC_ARB_STATS_EN
   logic [N*32-1:0] stat_pkts;
   logic [31:0] stat_stall;
`endif
   int errors = 0, checks = 0, cyc = 0, rx_cnt = 0, yum_cnt = 0, mptr = 0;
   int yum_mode = 0, yum_force = 0, bub = 0;
   logic [W-1:0] fq[N][$], mq[N][$], exp_q[$];
   bit hq[N][$];
   int ml[N][$], spkt[N];
   int vcyc[$], ycyc[$];

   noc_credit_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .CREDITS(C), .LEN_LSB(LL), .LEN_W(LW)) dut (
      .clock(clock),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_yummy(out_yummy),
`ifdef NOC_ARB_STATS_EN
      .stat_pkts(stat_pkts),
      .stat_stall(stat_stall),
`endif
      .credit_err(credit_err)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endfunction

   function automatic int at(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -1;
   endfunction

   always @(negedge clock) begin
      cyc++;
      if (out_yummy) ycyc.push_back(cyc);
      if (out_valid) begin
         vcyc.push_back(cyc);
         rx_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit got=%0h want=none", out_data);
         end else chk("flit", out_data, exp_q.pop_front());
      end
   end

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         logic v;
         v = 1'b0;
         if (fq[i].size() != 0) v = hq[i][0] || bub == 0 || $urandom_range(0, 2) != 0;
         req_valid[i] = v;
         if (v) req_data[i*W +: W] = fq[i][0];
         else req_data[i*W +: W] = {$urandom, $urandom};
      end
   endtask

   task automatic step();
      logic [N-1:0] fire;
      @(negedge clock);
      fire = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         if (fire[i]) begin
            void'(fq[i].pop_front());
            void'(hq[i].pop_front());
         end
      end
      drive_req();
      if (yum_force > 0) begin
         out_yummy = 1'b1;
         yum_force--;
         yum_cnt++;
      end else if (yum_mode != 0 && rx_cnt - yum_cnt > 0 && (yum_mode == 1 || $urandom_range(0, 1) == 1)) begin
         out_yummy = 1'b1;
         yum_cnt++;
      end else out_yummy = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 0);
      yum_mode = 1;
      bub = 0;
      run(12);
   endtask

   task automatic add_pkt(input int r, input int len);
      logic [W-1:0] f;
      f = {$urandom, $urandom};
      f[LL +: LW] = LW'(len);
      f[3:0] = 4'(r);
      fq[r].push_back(f);
      hq[r].push_back(1'b1);
      mq[r].push_back(f);
      for (int k = 0; k < len; k++) begin
         f = {$urandom, $urandom};
         fq[r].push_back(f);
         hq[r].push_back(1'b0);
         mq[r].push_back(f);
      end
      ml[r].push_back(len);
   endtask

   // whole packets leave in round-robin order over requesters that still hold packets
   task automatic load();
      int r;
      while (1) begin
         r = -1;
         for (int k = 0; k < N && r < 0; k++)
            if (ml[(mptr + k) % N].size() != 0) r = (mptr + k) % N;
         if (r < 0) break;
         for (int k = 0; k <= ml[r][0]; k++) exp_q.push_back(mq[r].pop_front());
         void'(ml[r].pop_front());
         spkt[r]++;
         mptr = (r + 1) % N;
      end
      drive_req();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '1;
      out_yummy = 1'b0;
      yum_force = 0;
      #1;
      chk("rst_req_ready", W'(req_ready), 0);
      chk("rst_out_valid", W'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_credit_err", W'(credit_err), 0);
`ifdef NOC_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("rst_stat_pkts", W'(stat_pkts[i*32 +: 32]), 0);
      chk("rst_stat_stall", W'(stat_stall), 0);
`endif
      for (int i = 0; i < N; i++) begin
         fq[i].delete();
         hq[i].delete();
         mq[i].delete();
         ml[i].delete();
         spkt[i] = 0;
      end
      exp_q.delete();
      mptr = 0;
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      yum_cnt = rx_cnt;
      drive_req();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d want=finish", cyc);
      $fatal(1);
   end

   initial begin
      int b, n;
      do_reset();
      // credit stall: 8 flits back-to-back, then exactly one more per yummy
      yum_mode = 0;
      b = vcyc.size();
      add_pkt(0, 10);
      load();
      run(20);
      chk("stall_count", 64'(vcyc.size() - b), 8);
      chk("stall_b2b", 64'(at(vcyc, b + 7) - at(vcyc, b)), 7);
      yum_force = 1;
      run(8);
      chk("yummy_one_more", 64'(vcyc.size() - b), 9);
      chk("yummy_latency", 64'(at(vcyc, b + 8)), 64'(at(ycyc, ycyc.size() - 1) + 2));
      yum_mode = 1;
      drain(100);
      // fairness: all requesters offer len=2 packets
      do_reset();
      yum_mode = 1;
      b = vcyc.size();
      for (int p = 0; p < 3; p++) for (int r = 0; r < N; r++) add_pkt(r, 2);
      load();
      drain(200);
      chk("fair_count", 64'(vcyc.size() - b), 36);
      chk("fair_no_bubble", 64'(at(vcyc, b + 35) - at(vcyc, b)), 35);
`ifdef NOC_ARB_STATS_EN
      for (int r = 0; r < N; r++) chk("stat_pkts", W'(stat_pkts[r*32 +: 32]), W'(spkt[r]));
`endif
      // zero-length packets alternate 1,3,1,3
      b = vcyc.size();
      add_pkt(1, 0);
      add_pkt(1, 0);
      add_pkt(3, 0);
      add_pkt(3, 0);
      load();
      drain(50);
      chk("zero_len_count", 64'(vcyc.size() - b), 4);
      chk("zero_len_b2b", 64'(at(vcyc, b + 3) - at(vcyc, b)), 3);
      // send and yummy together at cred=1
      yum_mode = 0;
      b = vcyc.size();
      add_pkt(2, 10);
      load();
      run(15);
      chk("simul_pre_count", 64'(vcyc.size() - b), 8);
      yum_force = 2;
      run(8);
      chk("simul_count", 64'(vcyc.size() - b), 10);
      chk("simul_first", 64'(at(vcyc, b + 8)), 64'(at(ycyc, ycyc.size() - 2) + 2));
      chk("simul_next", 64'(at(vcyc, b + 9) - at(vcyc, b + 8)), 1);
      yum_mode = 1;
      drain(100);
      // credit overflow
      yum_mode = 0;
      chk("err_clear", W'(credit_err), 0);
      yum_force = 1;
      run(3);
      chk("err_set", W'(credit_err), 1);
      run(5);
      chk("err_sticky", W'(credit_err), 1);
      b = vcyc.size();
      add_pkt(0, 10);
      load();
      run(20);
      chk("overflow_cred_held", 64'(vcyc.size() - b), 8);
      // reset during flit 3 of a len=5 packet, with rr_ptr away from 0
      do_reset();
      yum_mode = 1;
      b = vcyc.size();
      add_pkt(1, 0);
      add_pkt(2, 5);
      load();
      n = 0;
      while (vcyc.size() - b < 4 && n < 30) begin
         step();
         n++;
      end
      chk("mid_pkt_reached", 64'(vcyc.size() - b), 4);
      do_reset();
      yum_mode = 0;
      b = vcyc.size();
      add_pkt(3, 3);
      add_pkt(0, 3);
      add_pkt(1, 0);
      load();
      run(20);
      chk("post_rst_count", 64'(vcyc.size() - b), 8);
      chk("post_rst_b2b", 64'(at(vcyc, b + 7) - at(vcyc, b)), 7);
      chk("post_rst_left", 64'(exp_q.size()), 1);
      yum_mode = 1;
      drain(50);
      // randomized traffic with payload bubbles and sparse yummies
      for (int rd = 0; rd < 8; rd++) begin
         yum_mode = 2;
         bub = 1;
         n = $urandom_range(3, 8);
         repeat (n) add_pkt($urandom_range(0, N - 1), $urandom_range(0, 6));
         load();
         drain(600);
      end
      chk("final_credit_err", W'(credit_err), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/noc_credit_arbiter.md
# noc_credit_arbiter

Packet-atomic round-robin arbiter that shares one outbound valid/yummy NoC channel among N requesters in the bfm_driven bench. It sits between the requesters (BFMs or bridge-internal sources) and one `b2c_nocX` link into `chip`. It accepts flits over a ready/valid handshake, tracks downstream buffer credits, and never interleaves flits of two packets.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `DATA_WIDTH`, 64: flit width; matches `NOC_DATA_WIDTH`
- `CREDITS`, 8: downstream buffer depth, i.e. initial credit count
- `LEN_LSB`, 22: LSB of the payload-length field in the header flit
- `LEN_W`, 8: width of the payload-length field

- `clock`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester flit valid
- `req_data`  in  N_REQ*DATA_WIDTH  per-requester flit; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  N_REQ  per-requester flit accepted this cycle
- `out_valid`  out  1  NoC flit valid, registered
- `out_data`  out  DATA_WIDTH  NoC flit, registered
- `out_yummy`  in  1  credit return, one credit per asserted cycle
- `credit_err`  out  1  sticky; a yummy arrived while credits == CREDITS

## Operation
- **Packet format.** One header flit followed by `len = hdr[LEN_LSB +: LEN_W]` payload flits. `len == 0` is a header-only packet.
- **Acceptance.** A flit transfers when `req_valid[i] && req_ready[i]`. `req_ready` is combinational from state, `req_valid`, and credit count.
- **Credits.**
  - Counter `cred`, width clog2(CREDITS+1), reset to CREDITS.
  - Each accepted flit decrements it; each `out_yummy` cycle increments it.
  - Both in the same cycle leaves it unchanged.
  - `req_ready` is 0 for all requesters while `cred == 0`.
  - A yummy at `cred == CREDITS` (with no send) holds `cred` and sets `credit_err` until reset.
- **FSM states.** IDLE and BURST; `rr_ptr` holds the highest-priority requester.
  - **IDLE.** If `cred != 0` and any `req_valid` is set, grant the first valid requester searching from `rr_ptr` upward with wrap.
    - Assert `req_ready[grant]` and accept the header.
    - Load `remain = len`.
    - If `len == 0`, stay in IDLE and set `rr_ptr = grant+1 mod N_REQ`. Otherwise go to BURST.
  - **BURST.** `req_ready[grant] = req_valid[grant] && cred != 0`; all other ready bits are 0.
    - Each accepted flit decrements `remain`.
    - When the flit with `remain == 1` is accepted, go to IDLE and set `rr_ptr = grant+1 mod N_REQ`.
    - A requester bubble (`req_valid` low) holds the grant; there is no timeout.
- **Output register.**
  - `out_valid <= accepted`.
  - `out_data <= accepted flit`; otherwise `out_data` holds its last value.
- **Reset.** Asserting `rst_n` mid-packet aborts the packet immediately:
  - state = IDLE, `rr_ptr = 0`, `cred = CREDITS`
  - `out_valid = 0`, `out_data = 0`, `credit_err = 0`
  - `req_ready = 0` while in reset

## Timing
- Latency is 1 cycle: a flit accepted at edge k appears on `out_valid`/`out_data` after edge k+1.
- Throughput is 1 flit/cycle while credits are available, including header→payload and packet→next-packet transitions with no idle cycle.
- A yummy sampled at edge k makes a credit usable for acceptance in cycle k+1.
- With CREDITS outstanding and no yummies, exactly CREDITS flits go out back-to-back and then the arbiter stalls.

## Configuration
- `NOC_ARB_STATS_EN` defined adds two outputs:
  - `stat_pkts` (N_REQ*32): per-requester completed-packet count, incremented when the packet's last flit is accepted, wrapping modulo 2^32.
  - `stat_stall` (32): counts cycles where any `req_valid` is set and `cred == 0`.
  - Both reset to 0.
- `NOC_ARB_STATS_EN` undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `noc_arb_pkg`:
  - FSM state enum {IDLE, BURST}
  - default constants for the length-field position/width
  - function `hdr_len(flit)`
- One sub-module, `noc_rr_pick`: combinational rotating-priority picker (valid vector, `rr_ptr` → one-hot grant, index, any).

## Test plan
1. **Credit stall.** Requester 0 sends a header with len=10, CREDITS=8, no yummy. Required response:
   - 8 flits on `out_valid` in 8 consecutive cycles, then a stall.
   - One yummy → exactly 1 more flit, one cycle later.
2. **Fairness.** All 4 requesters continuously offer len=2 packets with unlimited yummies. Required response:
   - Grant order 0,1,2,3,0…
   - 3 flits per packet, no interleaving, no bubbles.
3. **Zero-length packets.** Requesters 1 and 3 each send len=0 headers. Required response: alternating single-flit packets 1,3,1,3, with `rr_ptr` advancing each cycle.
4. **Simultaneous send and yummy.** `cred`=1, and a send and a yummy occur in the same cycle. Required response: `cred` stays 1 and the next flit is accepted the following cycle.
5. **Credit overflow.** Yummy at `cred`=8. Required response: `credit_err`=1 and sticky; `cred` stays 8.
6. **Reset mid-packet.** `rst_n` pulsed low during flit 3 of a len=5 packet. Required response:
   - `out_valid`=0, `cred`=8, IDLE.
   - With `NOC_ARB_STATS_EN`, `stat_pkts` = 0 after reset.
